// File: rtl/gray_stream_ci_if.sv
`default_nettype none
// ============================================================================
// Module   : gray_stream_ci_if
// Brief    : CPU custom-instruction bus bundle for the grayscale stream engine.
// Revision : 1.0 - initial release
// ============================================================================
interface gray_stream_ci_if;
    logic        ciStart;
    logic        ciCke;
    logic [7:0]  ciN;
    logic [31:0] ciValueA;
    logic [31:0] ciValueB;
    logic        ciDone;
    logic [31:0] ciResult;

    modport master (
        output ciStart, ciCke, ciN, ciValueA, ciValueB,
        input  ciDone, ciResult
    );

    modport slave (
        input  ciStart, ciCke, ciN, ciValueA, ciValueB,
        output ciDone, ciResult
    );
endinterface
`default_nettype wire

// File: rtl/gray_stream_ci.sv
`default_nettype none
// ============================================================================
// Module   : gray_stream_ci
// Brief    : Custom-instruction engine converting RGB565 pixel quads to packed
//            grayscale words, buffered in a FIFO and collected by POP.
// Revision : 1.0 - initial release
// ============================================================================
module gray_stream_ci #(
    parameter logic [7:0] customInstructionId = 8'd0,
    parameter int         FIFO_DEPTH          = 16
) (
    input  wire logic          clock,
    input  wire logic          reset,
    gray_stream_ci_if.slave    ci
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_OCC_W = c_CNT_W + 1;

    localparam logic [1:0] c_OP_POP    = 2'd0;
    localparam logic [1:0] c_OP_STATUS = 2'd1;
    localparam logic [1:0] c_OP_CLEAR  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RESP     = 2'd1,
        S_POP_WAIT = 2'd2
    } state_t;

    // Luma weights 77/150/29 over 8-bit-expanded channels, scaled by 256.
    function automatic logic [7:0] f_gray(input logic [15:0] p);
        logic [15:0] sum;
        sum = 16'd77  * {8'd0, p[15:11], p[15:13]}
            + 16'd150 * {8'd0, p[10:5],  p[10:9]}
            + 16'd29  * {8'd0, p[4:0],   p[4:2]};
        sum = sum >> 8;
        return sum[7:0];
    endfunction

    state_t               r_state;
    logic [31:0]          r_result;
    logic                 r_s1_valid;
    logic [31:0]          r_s1_a;
    logic [31:0]          r_s1_b;
    logic                 r_s2_valid;
    logic [31:0]          r_s2_word;
    logic [31:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_overflow;
    logic                 r_underflow;

    logic                 w_push_acc;
    logic                 w_ctrl_acc;
    logic [1:0]           w_op;
    logic [1:0]           w_inflight;
    logic [c_OCC_W-1:0]   w_occupancy;
    logic                 w_room;
    logic                 w_fifo_empty;
    logic                 w_pop_now;
    logic                 w_clear;
    logic                 w_fifo_wr;
    logic [31:0]          w_status;

    always_comb begin
        w_push_acc   = ci.ciStart && (r_state == S_IDLE) && (ci.ciN == customInstructionId);
        w_ctrl_acc   = ci.ciStart && (r_state == S_IDLE) && (ci.ciN == customInstructionId + 8'd1);
        w_op         = ci.ciValueA[1:0];
        w_inflight   = {1'b0, r_s1_valid} + {1'b0, r_s2_valid};
        w_occupancy  = c_OCC_W'(r_count) + c_OCC_W'(w_inflight);
        w_room       = w_occupancy < c_OCC_W'(FIFO_DEPTH);
        w_fifo_empty = (r_count == '0);
        w_pop_now    = (w_ctrl_acc && (w_op == c_OP_POP) && !w_fifo_empty)
                    || ((r_state == S_POP_WAIT) && !w_fifo_empty);
        w_clear      = w_ctrl_acc && (w_op == c_OP_CLEAR);
        // A word landing in the same cycle as CLEAR is discarded.
        w_fifo_wr    = r_s2_valid && !w_clear;
        w_status     = {r_overflow, r_underflow, 12'd0, w_inflight, 16'(r_count)};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_result    <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_word   <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (ci.ciCke) begin
            if (w_clear) begin
                r_s1_valid  <= 1'b0;
                r_s2_valid  <= 1'b0;
                r_rd_ptr    <= '0;
                r_wr_ptr    <= '0;
                r_count     <= '0;
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                r_s1_valid <= w_push_acc && w_room;
                if (w_push_acc && w_room) begin
                    r_s1_a <= ci.ciValueA;
                    r_s1_b <= ci.ciValueB;
                end
                r_s2_valid <= r_s1_valid;
                r_s2_word  <= {f_gray(r_s1_b[31:16]), f_gray(r_s1_b[15:0]),
                               f_gray(r_s1_a[31:16]), f_gray(r_s1_a[15:0])};
                if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop_now) r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= r_count + {{c_PTR_W{1'b0}}, w_fifo_wr}
                                   - {{c_PTR_W{1'b0}}, w_pop_now};
                if (w_push_acc && !w_room) r_overflow <= 1'b1;
                if (w_ctrl_acc && (w_op == c_OP_POP) && w_fifo_empty && (w_inflight == 2'd0))
                    r_underflow <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_push_acc) begin
                        r_result <= '0;
                        r_state  <= S_RESP;
                    end else if (w_ctrl_acc) begin
                        r_result <= '0;
                        r_state  <= S_RESP;
                        if (w_op == c_OP_POP) begin
                            if (!w_fifo_empty) begin
                                r_result <= r_mem[r_rd_ptr];
                            end else if (w_inflight != 2'd0) begin
                                r_state <= S_POP_WAIT;
                            end
                        end else if (w_op == c_OP_STATUS) begin
                            r_result <= w_status;
                        end
                    end
                end
                S_POP_WAIT: begin
                    if (!w_fifo_empty) begin
                        r_result <= r_mem[r_rd_ptr];
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_result <= '0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_result <= '0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && ci.ciCke && w_fifo_wr) begin
            r_mem[r_wr_ptr] <= r_s2_word;
        end
    end

    // Done is qualified by the clock enable so it lasts exactly one enabled cycle.
    assign ci.ciDone   = (r_state == S_RESP) && ci.ciCke;
    assign ci.ciResult = ci.ciDone ? r_result : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_gray_stream_ci.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_stream_ci
// Brief    : Directed, table-driven self-checking bench for gray_stream_ci.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_stream_ci;

    localparam logic [7:0] c_PUSH = 8'd0;
    localparam logic [7:0] c_CTRL = 8'd1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gray_stream_ci_if bus ();

    gray_stream_ci #(
        .customInstructionId (8'd0),
        .FIFO_DEPTH          (16)
    ) dut (
        .clock (clk),
        .reset (rst),
        .ci    (bus)
    );

    typedef struct {
        logic [7:0]  n;
        logic [31:0] a;
        logic [31:0] b;
        int          gap;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl [19];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_gray(input logic [15:0] p);
        int r, g, b, y;
        r = (int'(p[15:11]) << 3) | (int'(p[15:11]) >> 2);
        g = (int'(p[10:5])  << 2) | (int'(p[10:5])  >> 4);
        b = (int'(p[4:0])   << 3) | (int'(p[4:0])   >> 2);
        y = (77 * r + 150 * g + 29 * b) / 256;
        return 8'(y);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input logic [31:0] b);
        return {ref_gray(b[31:16]), ref_gray(b[15:0]), ref_gray(a[31:16]), ref_gray(a[15:0])};
    endfunction

    task automatic do_ci(input logic [7:0] n, input logic [31:0] a, input logic [31:0] b,
                         input int gap, output logic [31:0] res, output int lat);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.ciStart  = 1'b1;
        bus.ciN      = n;
        bus.ciValueA = a;
        bus.ciValueB = b;
        @(negedge clk);
        bus.ciStart = 1'b0;
        lat = 1;
        while (bus.ciDone !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = bus.ciResult;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] res;
        int          lat;
        logic [31:0] words [17];
        logic [31:0] pa, pb;

        bus.ciStart  = 1'b0;
        bus.ciCke    = 1'b1;
        bus.ciN      = 8'd0;
        bus.ciValueA = 32'd0;
        bus.ciValueB = 32'd0;

        tbl[0]  = '{c_CTRL, 32'd1, 32'd0,        0, 32'h0000_0000, 1};
        tbl[1]  = '{c_PUSH, 32'h0, 32'h0,        0, 32'h0000_0000, 1};
        tbl[2]  = '{c_CTRL, 32'd0, 32'd0,        0, 32'h0000_0000, 2};
        tbl[3]  = '{c_CTRL, 32'd1, 32'd0,        0, 32'h0000_0000, 1};
        tbl[4]  = '{c_PUSH, 32'h1234ABCD, 32'hF800001F, 0, 32'h0000_0000, 1};
        tbl[5]  = '{c_CTRL, 32'd1, 32'd0,        2, 32'h0000_0001, 1};
        tbl[6]  = '{c_CTRL, 32'd0, 32'd0,        0, 32'h4C1C_3F87, 1};
        tbl[7]  = '{c_PUSH, 32'hFFFFFFFF, 32'hFFFF0000, 0, 32'h0000_0000, 1};
        tbl[8]  = '{c_CTRL, 32'd1, 32'd0,        0, 32'h0001_0000, 1};
        tbl[9]  = '{c_CTRL, 32'd0, 32'd0,        0, 32'hFF00_FFFF, 1};
        tbl[10] = '{c_CTRL, 32'd0, 32'd0,        0, 32'h0000_0000, 1};
        tbl[11] = '{c_CTRL, 32'd1, 32'd0,        0, 32'h4000_0000, 1};
        tbl[12] = '{c_CTRL, 32'd3, 32'd0,        0, 32'h0000_0000, 1};
        tbl[13] = '{c_CTRL, 32'd1, 32'd0,        0, 32'h4000_0000, 1};
        tbl[14] = '{c_CTRL, 32'd2, 32'd0,        0, 32'h0000_0000, 1};
        tbl[15] = '{c_CTRL, 32'd1, 32'd0,        0, 32'h0000_0000, 1};
        tbl[16] = '{c_PUSH, 32'hAAAA5555, 32'h0, 0, 32'h0000_0000, 1};
        tbl[17] = '{c_CTRL, 32'd2, 32'd0,        0, 32'h0000_0000, 1};
        tbl[18] = '{c_CTRL, 32'd1, 32'd0,        3, 32'h0000_0000, 1};

        // Reset held with a STATUS strobe pending: no completion allowed.
        bus.ciStart  = 1'b1;
        bus.ciN      = c_CTRL;
        bus.ciValueA = 32'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reset_no_done", {31'd0, bus.ciDone}, 32'd0);
        end
        bus.ciStart = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            do_ci(tbl[i].n, tbl[i].a, tbl[i].b, tbl[i].gap, res, lat);
            check($sformatf("vec%0d_result", i), res, tbl[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
        end

        // Unknown instruction id is ignored.
        @(negedge clk);
        bus.ciStart = 1'b1;
        bus.ciN     = 8'h07;
        @(negedge clk);
        bus.ciStart = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bad_id_no_done", {31'd0, bus.ciDone}, 32'd0);
            @(negedge clk);
        end

        // Fill to 16 words, then the 17th push is dropped.
        for (int i = 0; i < 17; i++) begin
            pa = 32'h0801F00F ^ (32'(i) * 32'h01230457);
            pb = ~pa + 32'(i);
            words[i] = ref_word(pa, pb);
            do_ci(c_PUSH, pa, pb, 0, res, lat);
            check($sformatf("fill%0d_done", i), 32'(lat), 32'd1);
        end
        do_ci(c_CTRL, 32'd1, 32'd0, 3, res, lat);
        check("status_full_overflow", res, 32'h8000_0010);
        for (int i = 0; i < 16; i++) begin
            do_ci(c_CTRL, 32'd0, 32'd0, 0, res, lat);
            check($sformatf("drain%0d", i), res, words[i]);
        end
        do_ci(c_PUSH, 32'h07E0F81F, 32'h4208C618, 0, res, lat);
        do_ci(c_CTRL, 32'd0, 32'd0, 2, res, lat);
        check("wrap_pop", res, ref_word(32'h07E0F81F, 32'h4208C618));
        do_ci(c_CTRL, 32'd1, 32'd0, 0, res, lat);
        check("status_after_wrap", res, 32'h8000_0000);
        do_ci(c_CTRL, 32'd2, 32'd0, 0, res, lat);
        do_ci(c_CTRL, 32'd1, 32'd0, 0, res, lat);
        check("status_after_clear", res, 32'h0000_0000);

        // Clock enable dropped for 5 cycles right after a PUSH is accepted.
        @(negedge clk);
        bus.ciStart  = 1'b1;
        bus.ciN      = c_PUSH;
        bus.ciValueA = 32'h1234ABCD;
        bus.ciValueB = 32'hF800001F;
        @(negedge clk);
        bus.ciStart = 1'b0;
        bus.ciCke   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("cke_low_no_done", {31'd0, bus.ciDone}, 32'd0);
            @(negedge clk);
        end
        bus.ciCke = 1'b1;
        #1;
        check("cke_resume_done", {31'd0, bus.ciDone}, 32'd1);
        check("cke_resume_result", bus.ciResult, 32'd0);
        do_ci(c_CTRL, 32'd1, 32'd0, 0, res, lat);
        check("cke_status_inflight", res, 32'h0001_0000);
        do_ci(c_CTRL, 32'd0, 32'd0, 0, res, lat);
        check("cke_pop", res, 32'h4C1C_3F87);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_stream_ci.md
Name: gray_stream_ci

Overview:
- Multi-cycle custom-instruction engine that lets the CPU stream RGB565 pixel pairs into a 2-stage grayscale conversion pipeline.
- Converted results are buffered as packed 4-pixel grayscale words in an internal FIFO, and the CPU collects them later with pop instructions.
- Sits on the CPU custom-instruction bus. It decouples issue of conversions from collection of results, and handles flow control and error flags.
- Per-pixel conversion uses the team's existing RGB565-to-8-bit grayscale converter. G(p) below denotes that function.

Parameters:
- customInstructionId, 8'd0, ciN value for PUSH; ciN = customInstructionId+1 selects CTRL.
- FIFO_DEPTH, 16, FIFO depth in 32-bit words; must be a power of 2, at least 4.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous active-high reset
- ciStart  input  1  instruction start strobe, single cycle
- ciCke  input  1  clock enable from CPU; state advances only when high
- ciN  input  8  instruction id
- ciValueA  input  32  PUSH: pixels 0/1; CTRL: opcode in [1:0]
- ciValueB  input  32  PUSH: pixels 2/3; CTRL: unused
- ciDone  output  1  single-cycle completion pulse
- ciResult  output  32  result; 0 whenever ciDone=0

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. On reset:
  - FIFO is emptied (count=0) and pipeline valid bits are cleared.
  - The overflow and underflow flags are cleared.
  - The FSM returns to IDLE, with ciDone=0 and ciResult=0.
  - Reset wins over ciCke and aborts any in-flight instruction mid-operation; no done is issued for it.
- Clock enable: when ciCke=0, every register holds, including pipeline, FIFO and FSM.
- Accept condition: an instruction is accepted when ciStart & ciCke & FSM=IDLE and ciN matches PUSH or CTRL. Any other ciN is ignored with no done.
- Packing: result byte0 = G(ciValueA[15:0]), byte1 = G(ciValueA[31:16]), byte2 = G(ciValueB[15:0]), byte3 = G(ciValueB[31:16]).
- PUSH:
  - If count + inflight < FIFO_DEPTH: the pixels enter pipeline stage 1.
    - Stage 2 registers the packed word.
    - The FIFO write happens on the next enabled cycle, i.e. the word is visible in count 3 enabled cycles after the accept.
  - Otherwise the data is dropped and the sticky overflow flag is set. There is no stall, to avoid deadlock, since a pop cannot issue while the CPU is stalled.
  - ciDone pulses on the enabled cycle after accept, with ciResult=0.
- CTRL opcode 0, POP:
  - FIFO non-empty: done next cycle, ciResult = head word, head advances.
  - FIFO empty with inflight>0: FSM enters POP_WAIT and completes the pop the cycle after the word lands, at most 3 cycles.
  - FIFO empty with inflight=0: done next cycle, ciResult=0, sticky underflow flag set.
- CTRL opcode 1, STATUS: done next cycle with ciResult = {overflow[31], underflow[30], 12'b0, inflight[17:16], 16-bit zero-extended count}.
- CTRL opcode 2, CLEAR: empties the FIFO, invalidates the pipeline and clears both flags; done next cycle, ciResult=0.
- CTRL opcode 3: reserved; done next cycle, ciResult=0, no side effects.
- FSM states:
  - IDLE goes to RESP on accept, or to POP_WAIT on a pop that must wait.
  - POP_WAIT goes to RESP when the FIFO becomes non-empty.
  - RESP drives ciDone=1 and the registered result for exactly one enabled cycle, then returns to IDLE.
- Simultaneous events:
  - A FIFO write from stage 2 and a pop in the same cycle are both honoured; count is unchanged.
  - An in-flight push completing on the same cycle as a CLEAR is discarded.
- Pointers: read and write pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits wide.

Test Plan:
- Reset then STATUS -> done on cycle 2, ciResult=0x00000000. Hold reset with ciStart high -> ciDone stays 0.
- PUSH A=0x00000000, B=0x00000000, then immediate POP -> POP waits in POP_WAIT and returns 0x00000000. STATUS then shows count=0, inflight=0.
- PUSH A=0x1234ABCD, B=0xF800001F; after 3 cycles, STATUS count=1. POP -> ciResult = {G(0xF800),G(0x001F),G(0x1234),G(0xABCD)}.
- PUSH 17 words with FIFO_DEPTH=16 -> the 17th is dropped and STATUS = 0x80000010. Then 16 POPs return the words in order, with pointer wrap exercised by a following push/pop pair.
- POP when fully empty -> ciResult=0 and STATUS bit30=1. CLEAR -> STATUS=0x00000000.
- Toggle ciCke low for 5 cycles mid-PUSH -> pipeline frozen, no done pulse while low. Completion timing shifts by exactly 5 cycles.
